// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory stage.
// Contents: FSM state encoding, counter width, load/store opcodes, common byte masks.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } dmem_state_e;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 4;
   localparam int unsigned CNT_W  = 4;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   localparam logic [3:0] MASK_B0 = 4'b0001;
   localparam logic [3:0] MASK_H0 = 4'b0011;
   localparam logic [3:0] MASK_H1 = 4'b1100;
   localparam logic [3:0] MASK_W  = 4'b1111;

endpackage

// File: rtl/dmem_bank.sv
// Word-wide memory built from four independent byte lanes.
// Ports: clk; we[3:0] per-lane write enable; idx word index (shared by read and write);
//        wdata lane-aligned write word; rdata asynchronous read of the word at idx.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic [LANES-1:0]  we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   // One byte array per lane so each lane can be written on its own.
   for (genvar b = 0; b < LANES; b++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (we[b]) mem[idx] <= wdata[8*b +: 8];
      end

      assign rdata[8*b +: 8] = mem[idx];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller behind the load/store unit: accepts one load or store per
// request, commits it LATENCY cycles later and returns the full read word.
// Ports: clk; rst (sync, active-low); cs (active-low request); wr (1=load, 0=store);
//        mask byte-lane store enables; addr byte address; data_wr store data;
//        data_rd registered load word; valid completion pulse; busy combinational
//        stall request; err out-of-range pulse alongside valid.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        wr,
   input  logic [3:0]  mask,
   input  logic [31:0] addr,
   input  logic [31:0] data_wr,
   output logic [31:0] data_rd,
   output logic        valid,
   output logic        busy,
   output logic        err
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   // With a single-cycle latency the commit edge is the accept edge, so the
   // commit must use the live request rather than the latched copy.
   localparam bit          SAME_EDGE = (LATENCY == 1);

   dmem_state_e state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic accept_c, commit_c;

   logic [IDX_W-1:0]  idx_q;
   logic              oor_q, ld_q;
   logic [LANES-1:0]  mask_q;
   logic [DATA_W-1:0] wdata_q;

   logic [IDX_W-1:0]  live_idx_c, req_idx_c;
   logic              live_oor_c, req_oor_c, req_ld_c;
   logic [LANES-1:0]  req_mask_c, bank_we_c;
   logic [DATA_W-1:0] req_wdata_c, bank_rd_c;
   logic              unused_addr_lsb;

   assign unused_addr_lsb = ^addr[1:0];

   // Range check: any address bit above the word index means out of range.
   assign live_idx_c = addr[IDX_W+1:2];
   assign live_oor_c = |addr[31:IDX_W+2];

   assign req_idx_c   = SAME_EDGE ? live_idx_c : idx_q;
   assign req_oor_c   = SAME_EDGE ? live_oor_c : oor_q;
   assign req_ld_c    = SAME_EDGE ? wr         : ld_q;
   assign req_mask_c  = SAME_EDGE ? mask       : mask_q;
   assign req_wdata_c = SAME_EDGE ? data_wr    : wdata_q;

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_rd <= '0;
         valid   <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid   <= commit_c;
         err     <= commit_c && req_oor_c;
         if (commit_c && req_ld_c) data_rd <= req_oor_c ? '0 : bank_rd_c;
      end
   end

   // Request capture; only ever loaded on an accepted request.
   always_ff @(posedge clk) begin
      if (rst && accept_c) begin
         idx_q   <= live_idx_c;
         oor_q   <= live_oor_c;
         ld_q    <= wr;
         mask_q  <= mask;
         wdata_q <= data_wr;
      end
   end

   // Next-state, counter and busy.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept_c = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (!cs) begin
               accept_c = 1'b1;
               busy     = 1'b1;
               cnt_d    = CNT_W'(LATENCY - 1);
               state_d  = SAME_EDGE ? DONE : WAIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            busy  = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Every entry into DONE is a commit edge.
   assign commit_c  = (state_d == DONE);
   assign bank_we_c = (rst && commit_c && !req_ld_c && !req_oor_c) ? req_mask_c : '0;

   dmem_bank #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_bank (
      .clk   (clk),
      .we    (bank_we_c),
      .idx   (req_idx_c),
      .wdata (req_wdata_c),
      .rdata (bank_rd_c)
   );

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: a LATENCY=2 instance carries most scenarios,
// a LATENCY=4 instance covers timing at a longer latency and reset during WAIT.
// Both share the request bus; the idle instance is held in reset.
module tb_dmem_ctrl;

   localparam int unsigned DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst2, rst4, cs, wr;
   logic [3:0]  mask;
   logic [31:0] addr, data_wr;
   logic [31:0] data_rd2, data_rd4;
   logic        valid2, valid4, busy2, busy4, err2, err4;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem_m [int unsigned];
   logic [31:0] last_rd;

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) u_dut2 (
      .clk(clk), .rst(rst2), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
      .data_wr(data_wr), .data_rd(data_rd2), .valid(valid2), .busy(busy2), .err(err2)
   );

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst4), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
      .data_wr(data_wr), .data_rd(data_rd4), .valid(valid4), .busy(busy4), .err(err4)
   );

   // Reference: word-addressed memory with byte merge, plus the last load result.
   function automatic void model_step(input bit ld, input logic [31:0] a, input logic [3:0] m,
                                      input logic [31:0] d, output logic [31:0] exp_rd,
                                      output bit exp_err);
      int unsigned w;
      logic [31:0] word;
      w       = 32'(a >> 2);
      exp_err = (w >= DEPTH);
      if (ld) begin
         exp_rd  = exp_err ? 32'h0 : mem_m[w];
         last_rd = exp_rd;
      end else begin
         if (!exp_err) begin
            word = mem_m.exists(w) ? mem_m[w] : 32'h0;
            for (int b = 0; b < 4; b++) if (m[b]) word[8*b +: 8] = d[8*b +: 8];
            mem_m[w] = word;
         end
         exp_rd = last_rd;
      end
   endfunction

   // One isolated request from idle; reports what the selected instance did.
   task automatic do_txn(input bit inst4, input bit ld, input logic [31:0] a, input logic [3:0] m,
                         input logic [31:0] d, output int vcyc, output logic [31:0] rd,
                         output logic e, output logic b0, output logic b1, output logic bdone,
                         output logic vafter);
      int n;
      cs = 1'b0; wr = ld; addr = a; mask = m; data_wr = d;
      #1 b0 = inst4 ? busy4 : busy2;
      @(negedge clk);
      cs = 1'b1; wr = 1'bx; mask = 'x; data_wr = 'x; addr = 'x;
      #1 b1 = inst4 ? busy4 : busy2;
      n = 1;
      while (!(inst4 ? valid4 : valid2) && n < 20) begin
         @(negedge clk);
         n++;
      end
      vcyc  = (inst4 ? valid4 : valid2) ? n : -1;
      rd    = inst4 ? data_rd4 : data_rd2;
      e     = inst4 ? err4 : err2;
      bdone = inst4 ? busy4 : busy2;
      @(negedge clk);
      vafter = inst4 ? valid4 : valid2;
   endtask

   task automatic test_reset();
      bit seen;
      rst2 = 1'b0; rst4 = 1'b0; cs = 1'b1; wr = 1'b0; mask = '0; addr = '0; data_wr = '0;
      repeat (2) @(negedge clk);
      n_tests++; if (data_rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_data_rd: got %h want 0", data_rd2); end
      n_tests++; if (valid2 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid2); end
      n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy2); end
      n_tests++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err2); end
      n_tests++; if (data_rd4 !== 32'h0) begin n_fail++; $display("FAIL reset_data_rd4: got %h want 0", data_rd4); end
      last_rd = 32'h0;
      // Request present during reset must not be accepted.
      cs = 1'b0; wr = 1'b1; addr = 32'h10;
      @(negedge clk);
      cs = 1'b1; rst2 = 1'b1;
      #1;
      n_tests++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL reset_vs_cs_busy: got %b want 0", busy2); end
      seen = 1'b0;
      repeat (4) begin @(negedge clk); if (valid2 !== 1'b0) seen = 1'b1; end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_vs_cs_valid: got %b want 0", seen); end
   endtask

   task automatic test_word();
      int v; logic [31:0] rd, er; logic e, b0, b1, bd, va; bit ee;
      do_txn(0, 0, 32'h10, 4'hF, 32'hDEADBEEF, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h10, 4'hF, 32'hDEADBEEF, er, ee);
      n_tests++; if (v !== 2) begin n_fail++; $display("FAIL word_store_latency: got %0d want 2", v); end
      n_tests++; if (b0 !== 1'b1 || b1 !== 1'b1) begin n_fail++; $display("FAIL word_store_busy: got %b%b want 11", b0, b1); end
      n_tests++; if (bd !== 1'b0) begin n_fail++; $display("FAIL word_store_busy_done: got %b want 0", bd); end
      n_tests++; if (va !== 1'b0) begin n_fail++; $display("FAIL word_store_pulse_len: got %b want 0", va); end
      n_tests++; if (rd !== er) begin n_fail++; $display("FAIL word_store_keeps_rd: got %h want %h", rd, er); end
      do_txn(0, 1, 32'h10, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      model_step(1, 32'h10, 4'h0, 32'h0, er, ee);
      n_tests++; if (v !== 2) begin n_fail++; $display("FAIL word_load_latency: got %0d want 2", v); end
      n_tests++; if (rd !== er) begin n_fail++; $display("FAIL word_load_data: got %h want %h", rd, er); end
      n_tests++; if (b0 !== 1'b1 || b1 !== 1'b1 || bd !== 1'b0) begin n_fail++; $display("FAIL word_load_busy: got %b%b%b want 110", b0, b1, bd); end
      n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL word_load_err: got %b want 0", e); end
   endtask

   task automatic test_byte_mask();
      int v; logic [31:0] rd, er; logic e, b0, b1, bd, va; bit ee;
      do_txn(0, 0, 32'h20, 4'hF, 32'h11223344, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h20, 4'hF, 32'h11223344, er, ee);
      do_txn(0, 0, 32'h20, 4'b1000, 32'hAA000000, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h20, 4'b1000, 32'hAA000000, er, ee);
      do_txn(0, 1, 32'h22, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      model_step(1, 32'h22, 4'h0, 32'h0, er, ee);
      n_tests++; if (rd !== er) begin n_fail++; $display("FAIL byte_mask_merge: got %h want %h", rd, er); end
      do_txn(0, 0, 32'h20, 4'b0000, 32'hFFFFFFFF, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h20, 4'b0000, 32'hFFFFFFFF, er, ee);
      n_tests++; if (v !== 2) begin n_fail++; $display("FAIL zero_mask_valid: got %0d want 2", v); end
      do_txn(0, 1, 32'h20, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      model_step(1, 32'h20, 4'h0, 32'h0, er, ee);
      n_tests++; if (rd !== er) begin n_fail++; $display("FAIL zero_mask_unchanged: got %h want %h", rd, er); end
   endtask

   task automatic test_back_to_back();
      int v; logic [31:0] rd, er; logic e, b0, b1, bd, va; bit ee;
      do_txn(0, 0, 32'h30, 4'hF, 32'h99, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h30, 4'hF, 32'h99, er, ee);
      cs = 1'b0; wr = 1'b0; addr = 32'h30; mask = 4'hF; data_wr = 32'h5;
      @(negedge clk);
      // Load presented while the store waits; must not disturb the store.
      wr = 1'b1; mask = 'x; data_wr = 'x;
      #1;
      n_tests++; if (valid2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL b2b_wait: got valid=%b busy=%b want 0/1", valid2, busy2); end
      @(negedge clk);
      n_tests++; if (valid2 !== 1'b1 || busy2 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_done: got valid=%b busy=%b want 1/1", valid2, busy2); end
      @(negedge clk);
      cs = 1'b1; wr = 1'bx; addr = 'x;
      #1;
      n_tests++; if (valid2 !== 1'b0 || busy2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_wait: got valid=%b busy=%b want 0/1", valid2, busy2); end
      model_step(0, 32'h30, 4'hF, 32'h5, er, ee);
      model_step(1, 32'h30, 4'h0, 32'h0, er, ee);
      @(negedge clk);
      n_tests++; if (valid2 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_valid: got %b want 1", valid2); end
      n_tests++; if (data_rd2 !== er) begin n_fail++; $display("FAIL b2b_raw_data: got %h want %h", data_rd2, er); end
      @(negedge clk);
      n_tests++; if (valid2 !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse_len: got %b want 0", valid2); end
   endtask

   task automatic test_out_of_range();
      int v; logic [31:0] rd, er; logic e, b0, b1, bd, va; bit ee;
      do_txn(0, 0, 32'h0, 4'hF, 32'hCAFEF00D, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h0, 4'hF, 32'hCAFEF00D, er, ee);
      do_txn(0, 1, 32'h4, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      model_step(1, 32'h4, 4'h0, 32'h0, er, ee);
      do_txn(0, 1, 32'h1000, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      model_step(1, 32'h1000, 4'h0, 32'h0, er, ee);
      n_tests++; if (rd !== er) begin n_fail++; $display("FAIL oor_load_data: got %h want %h", rd, er); end
      n_tests++; if (e !== 1'(ee) || v !== 2) begin n_fail++; $display("FAIL oor_load_err: got err=%b lat=%0d want %b/2", e, v, ee); end
      do_txn(0, 0, 32'h1000, 4'hF, 32'hBAD0BAD0, v, rd, e, b0, b1, bd, va);
      model_step(0, 32'h1000, 4'hF, 32'hBAD0BAD0, er, ee);
      n_tests++; if (e !== 1'(ee)) begin n_fail++; $display("FAIL oor_store_err: got %b want %b", e, ee); end
      do_txn(0, 1, 32'h0, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      model_step(1, 32'h0, 4'h0, 32'h0, er, ee);
      n_tests++; if (rd !== er || e !== 1'b0) begin n_fail++; $display("FAIL oor_no_alias: got %h err=%b want %h/0", rd, e, er); end
   endtask

   task automatic test_random();
      int v; logic [31:0] rd, er, a, d; logic [3:0] m; logic e, b0, b1, bd, va; bit ee, ld;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         do_txn(0, 0, 32'h400 + 32'(4 * i), 4'hF, d, v, rd, e, b0, b1, bd, va);
         model_step(0, 32'h400 + 32'(4 * i), 4'hF, d, er, ee);
      end
      for (int k = 0; k < 40; k++) begin
         a = 32'h400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(12, 31));
         ld = 1'($urandom_range(0, 1));
         m  = 4'($urandom);
         d  = $urandom;
         do_txn(0, ld, a, m, d, v, rd, e, b0, b1, bd, va);
         model_step(ld, a, m, d, er, ee);
         n_tests++; if (rd !== er) begin n_fail++; $display("FAIL rand_data[%0d]: ld=%b addr=%h got %h want %h", k, ld, a, rd, er); end
         n_tests++; if (e !== 1'(ee) || v !== 2 || va !== 1'b0) begin n_fail++; $display("FAIL rand_ctrl[%0d]: got err=%b lat=%0d after=%b want %b/2/0", k, e, v, va, ee); end
      end
   endtask

   task automatic test_reset_mid_wait();
      int v; logic [31:0] rd; logic e, b0, b1, bd, va; bit seen;
      rst2 = 1'b0; rst4 = 1'b1; cs = 1'b1;
      @(negedge clk);
      do_txn(1, 0, 32'h40, 4'hF, 32'h11111111, v, rd, e, b0, b1, bd, va);
      n_tests++; if (v !== 4) begin n_fail++; $display("FAIL lat4_latency: got %0d want 4", v); end
      cs = 1'b0; wr = 1'b0; addr = 32'h40; mask = 4'hF; data_wr = 32'h77;
      @(negedge clk);
      cs = 1'b1; wr = 1'bx; addr = 'x; mask = 'x; data_wr = 'x;
      @(negedge clk);
      rst4 = 1'b0;
      @(negedge clk);
      rst4 = 1'b1;
      #1;
      n_tests++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL midwait_busy: got %b want 0", busy4); end
      seen = (valid4 !== 1'b0);
      repeat (6) begin @(negedge clk); if (valid4 !== 1'b0) seen = 1'b1; end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midwait_no_valid: got %b want 0", seen); end
      do_txn(1, 1, 32'h40, 4'h0, 32'h0, v, rd, e, b0, b1, bd, va);
      n_tests++; if (rd !== 32'h11111111 || v !== 4) begin n_fail++; $display("FAIL midwait_no_write: got %h lat=%0d want 11111111/4", rd, v); end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_word();
      test_byte_mask();
      test_back_to_back();
      test_out_of_range();
      test_random();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
